// File: rtl/fp_cmp_pkg.sv
// Shared codes and helpers for the pipelined FloPoCo-format comparator.
package fp_cmp_pkg;

    typedef enum logic [2:0] {
        CMP_LT = 3'd0,
        CMP_LE = 3'd1,
        CMP_GT = 3'd2,
        CMP_GE = 3'd3,
        CMP_EQ = 3'd4,
        CMP_NE = 3'd5
    } cmp_mode_e;

    localparam logic [1:0] EXC_ZERO = 2'b00;
    localparam logic [1:0] EXC_NORM = 2'b01;
    localparam logic [1:0] EXC_INF  = 2'b10;
    localparam logic [1:0] EXC_NAN  = 2'b11;

    function automatic int fp_w(input int we, input int wf);
        return we + wf + 3;
    endfunction

endpackage

// File: rtl/fp_compare_pipe_key.sv
// Order key for one FloPoCo operand: sign, zero-forced magnitude and NaN flag.
module fp_order_key
    import fp_cmp_pkg::*;
#(
    parameter int WE = 11,
    parameter int WF = 12,
    localparam int W  = fp_w(WE, WF),
    localparam int MW = WE + WF + 2
) (
    input  logic [W-1:0]  x_i,
    output logic          sign_o,
    output logic [MW-1:0] mag_o,
    output logic          is_nan_o
);

    logic [1:0] exc;

    assign exc      = x_i[W-1 -: 2];
    assign sign_o   = x_i[WE+WF];
    // zero operands collapse to an all-zero key so +0 and -0 are equal
    assign mag_o    = (exc == EXC_ZERO) ? '0 : {exc, x_i[WE+WF-1:0]};
    assign is_nan_o = (exc == EXC_NAN);

endmodule

// File: rtl/fp_compare_pipe.sv
// Pipelined FloPoCo comparator: six predicates, NaN detection, min/max and tag.
// LAT=1 registers only the output; LAT=2 adds a key register; LAT=3 splits the compare.
module fp_compare_pipe
    import fp_cmp_pkg::*;
#(
    parameter int WE   = 11,
    parameter int WF   = 12,
    parameter int LAT  = 1,
    parameter int TAGW = 4,
    localparam int W   = fp_w(WE, WF)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [2:0]      mode,
    input  logic [TAGW-1:0] tag_in,
    input  logic [W-1:0]    inA,
    input  logic [W-1:0]    inB,
    output logic            out_valid,
    output logic            result,
    output logic            unordered,
    output logic [W-1:0]    min_out,
    output logic [W-1:0]    max_out,
    output logic [TAGW-1:0] tag_out
);

    localparam int MW  = WE + WF + 2;
    localparam int LOW = MW / 2;
    localparam int HIW = MW - LOW;

    typedef struct packed {
        logic [2:0]      mode;
        logic [TAGW-1:0] tag;
        logic [W-1:0]    a;
        logic [W-1:0]    b;
        logic            sa;
        logic            sb;
        logic            za;
        logic            zb;
        logic            nan;
    } ctl_t;

    typedef struct packed {
        logic hi_lt;
        logic hi_eq;
        logic lo_lt;
        logic lo_eq;
    } cmp_t;

    if (LAT < 1 || LAT > 3) begin : g_lat_check
        $error("fp_compare_pipe: LAT must be in 1..3");
    end

    logic          sign_a, sign_b, nan_a, nan_b;
    logic [MW-1:0] mag_a, mag_b;

    fp_order_key #(.WE(WE), .WF(WF)) u_key_a (
        .x_i      (inA),
        .sign_o   (sign_a),
        .mag_o    (mag_a),
        .is_nan_o (nan_a)
    );

    fp_order_key #(.WE(WE), .WF(WF)) u_key_b (
        .x_i      (inB),
        .sign_o   (sign_b),
        .mag_o    (mag_b),
        .is_nan_o (nan_b)
    );

    ctl_t ctl_d;

    always_comb begin
        ctl_d      = '0;
        ctl_d.mode = mode;
        ctl_d.tag  = tag_in;
        ctl_d.a    = inA;
        ctl_d.b    = inB;
        ctl_d.sa   = sign_a;
        ctl_d.sb   = sign_b;
        ctl_d.za   = (mag_a == '0);
        ctl_d.zb   = (mag_b == '0);
        ctl_d.nan  = nan_a | nan_b;
    end

    logic          c_valid;
    ctl_t          c_ctl;
    logic [MW-1:0] c_mag_a, c_mag_b;

    if (LAT >= 2) begin : g_key_reg
        logic          valid_q;
        ctl_t          ctl_q;
        logic [MW-1:0] mag_a_q, mag_b_q;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                valid_q <= 1'b0;
                ctl_q   <= '0;
                mag_a_q <= '0;
                mag_b_q <= '0;
            end else begin
                valid_q <= in_valid;
                if (in_valid) begin
                    ctl_q   <= ctl_d;
                    mag_a_q <= mag_a;
                    mag_b_q <= mag_b;
                end
            end
        end

        assign c_valid = valid_q;
        assign c_ctl   = ctl_q;
        assign c_mag_a = mag_a_q;
        assign c_mag_b = mag_b_q;
    end else begin : g_key_comb
        assign c_valid = in_valid;
        assign c_ctl   = ctl_d;
        assign c_mag_a = mag_a;
        assign c_mag_b = mag_b;
    end

    cmp_t cmp_d;

    always_comb begin
        cmp_d       = '0;
        cmp_d.hi_lt = (c_mag_a[MW-1 -: HIW] <  c_mag_b[MW-1 -: HIW]);
        cmp_d.hi_eq = (c_mag_a[MW-1 -: HIW] == c_mag_b[MW-1 -: HIW]);
        cmp_d.lo_lt = (c_mag_a[LOW-1:0] <  c_mag_b[LOW-1:0]);
        cmp_d.lo_eq = (c_mag_a[LOW-1:0] == c_mag_b[LOW-1:0]);
    end

    logic m_valid;
    ctl_t m_ctl;
    cmp_t m_cmp;

    if (LAT >= 3) begin : g_cmp_reg
        logic valid_q;
        ctl_t ctl_q;
        cmp_t cmp_q;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                valid_q <= 1'b0;
                ctl_q   <= '0;
                cmp_q   <= '0;
            end else begin
                valid_q <= c_valid;
                if (c_valid) begin
                    ctl_q <= c_ctl;
                    cmp_q <= cmp_d;
                end
            end
        end

        assign m_valid = valid_q;
        assign m_ctl   = ctl_q;
        assign m_cmp   = cmp_q;
    end else begin : g_cmp_comb
        assign m_valid = c_valid;
        assign m_ctl   = c_ctl;
        assign m_cmp   = cmp_d;
    end

    logic mag_lt, mag_eq, a_lt, a_eq, a_gt, result_d, swap_d;

    always_comb begin
        mag_lt = m_cmp.hi_lt | (m_cmp.hi_eq & m_cmp.lo_lt);
        mag_eq = m_cmp.hi_eq & m_cmp.lo_eq;
        a_lt   = 1'b0;
        a_eq   = 1'b0;
        if (m_ctl.za && m_ctl.zb) begin
            a_eq = 1'b1;
        end else if (m_ctl.za) begin
            a_lt = !m_ctl.sb;
        end else if (m_ctl.zb) begin
            a_lt = m_ctl.sa;
        end else if (m_ctl.sa != m_ctl.sb) begin
            a_lt = m_ctl.sa;
        end else begin
            // same sign: negative operands reverse the magnitude order
            a_eq = mag_eq;
            a_lt = m_ctl.sa ? (!mag_lt && !mag_eq) : mag_lt;
        end
        a_gt = !a_lt && !a_eq;

        result_d = 1'b0;
        if (m_ctl.nan) begin
            result_d = (m_ctl.mode == CMP_NE);
        end else begin
            case (m_ctl.mode)
                CMP_LT:  result_d = a_lt;
                CMP_LE:  result_d = a_lt | a_eq;
                CMP_GT:  result_d = a_gt;
                CMP_GE:  result_d = !a_lt;
                CMP_EQ:  result_d = a_eq;
                CMP_NE:  result_d = !a_eq;
                default: result_d = 1'b0;
            endcase
        end
        swap_d = !m_ctl.nan && a_gt;
    end

    logic            out_valid_q, result_q, unordered_q;
    logic [W-1:0]    min_q, max_q;
    logic [TAGW-1:0] tag_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q <= 1'b0;
            result_q    <= 1'b0;
            unordered_q <= 1'b0;
            min_q       <= '0;
            max_q       <= '0;
            tag_q       <= '0;
        end else begin
            out_valid_q <= m_valid;
            if (m_valid) begin
                result_q    <= result_d;
                unordered_q <= m_ctl.nan;
                tag_q       <= m_ctl.tag;
                if (m_ctl.nan) begin
                    min_q <= m_ctl.a;
                    max_q <= m_ctl.a;
                end else if (swap_d) begin
                    min_q <= m_ctl.b;
                    max_q <= m_ctl.a;
                end else begin
                    min_q <= m_ctl.a;
                    max_q <= m_ctl.b;
                end
            end
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign unordered = unordered_q;
    assign min_out   = min_q;
    assign max_out   = max_q;
    assign tag_out   = tag_q;

endmodule
